// File: rtl/jtag_seq_pkg.sv
// -----------------------------------------------------------------------------
// jtag_seq_pkg
//   Shared definitions for the JTAG master sequencer: host command opcodes,
//   sequencer state encoding and the fixed TAP-reset pattern length.
//   Optional build macro used by the sequencer: JTAG_SEQ_TRST_EN.
// -----------------------------------------------------------------------------
package jtag_seq_pkg;

    // Host command opcodes; encodings 4..7 are illegal.
    typedef enum logic [2:0] {
        OP_RESET     = 3'd0,
        OP_TMS_SEQ   = 3'd1,
        OP_SCAN      = 3'd2,
        OP_SCAN_FLIP = 3'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOW,
        ST_HIGH,
        ST_STORE
    } state_e;

    // TAP reset: this many TMS=1 bits, followed by a single TMS=0 bit.
    localparam int unsigned RESET_TMS_ONES = 5;
    localparam int unsigned RESET_BITS     = RESET_TMS_ONES + 1;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage : jtag_seq_pkg

// File: rtl/jtag_tck_gen.sv
// -----------------------------------------------------------------------------
// jtag_tck_gen
//   TCK phase generator. While run is high it produces a TCK with a half
//   period of TCK_DIV clk_i cycles, starting low. When run drops the phase
//   counter restarts and TCK is held low, which stretches TCK while the
//   sequencer waits for data.
//
// Ports
//   clk_i, rst_n_i : system clock, asynchronous active-low reset
//   run            : enable TCK toggling
//   tck            : registered TCK output
//   rise_stb       : high in the cycle whose closing clk_i edge raises tck
//   bit_done_stb   : high in the cycle whose closing clk_i edge lowers tck
//                    (the end of one full JTAG bit)
// -----------------------------------------------------------------------------
module jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run,
    output logic tck,
    output logic rise_stb,
    output logic bit_done_stb
);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       phase_end;

    assign phase_end = run && (cnt_q == 8'(TCK_DIV - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!run) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (phase_end) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: flops take non-blocking assignments so every register sees
        // the pre-edge value of every other register, as the hardware does.
        if (!rst_n_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

    assign tck          = tck_q;
    assign rise_stb     = phase_end && !tck_q;
    assign bit_done_stb = phase_end &&  tck_q;

endmodule : jtag_tck_gen

// File: rtl/jtag_seq_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_seq_ctrl
//   Synthesizable JTAG master sequencer. Accepts host commands (TAP reset,
//   TMS sequence, scan, scan with TMS raised on the final bit), streams
//   32-bit TMS/TDI words in, drives divided TCK/TMS/TDI and returns the
//   captured TDO bits as 32-bit words (first bit at the LSB).
//
//   Optional build macro JTAG_SEQ_TRST_EN adds trst_n_o, held low during the
//   TMS=1 portion of a TAP reset command.
//
// Ports
//   clk_i, rst_n_i            : system clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   : command handshake (ready only in IDLE)
//   cmd_op_i, cmd_nbits_i     : opcode and bit count of the command
//   wr_valid_i/wr_ready_o     : outbound TMS/TDI word handshake, wr_data_i
//   rd_valid_o/rd_ready_i     : captured TDO word handshake, rd_data_o
//   busy_o                    : high whenever the sequencer is not idle
//   err_o                     : one-cycle pulse after an illegal op is taken
//   tck_o, tms_o, tdi_o       : registered JTAG outputs
//   tdo_i                     : JTAG TDO input
//   trst_n_o                  : (JTAG_SEQ_TRST_EN only) TAP reset, active-low
// -----------------------------------------------------------------------------
module jtag_seq_ctrl
    import jtag_seq_pkg::*;
#(
    parameter int unsigned TCK_DIV = 4,
    parameter int unsigned NBITS_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [2:0]         cmd_op_i,
    input  logic [NBITS_W-1:0] cmd_nbits_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [31:0]        wr_data_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [31:0]        rd_data_o,
    output logic               busy_o,
    output logic               err_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
`ifdef JTAG_SEQ_TRST_EN
    output logic               trst_n_o,
`endif
    input  logic               tdo_i
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [NBITS_W-1:0] nbits_q, nbits_d;
    logic [NBITS_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NBITS_W-1:0] bit_cnt_inc;
    logic [4:0]         idx_q, idx_d;
    logic [31:0]        word_q, word_d;
    logic [31:0]        rd_q, rd_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               err_q, err_d;

    logic               load_bit;
    logic               bit_val;
    logic               scan_op;
    logic               cmd_done;
    logic               run;
    logic               tck;
    logic               rise_stb;
    logic               bit_done_stb;

    // TCK only runs while a bit is actually being shifted; FETCH and STORE
    // stall it low.
    assign run = (state_q == ST_LOW) || (state_q == ST_HIGH);

    jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .run          (run),
        .tck          (tck),
        .rise_stb     (rise_stb),
        .bit_done_stb (bit_done_stb)
    );

    assign scan_op     = (op_q == OP_SCAN) || (op_q == OP_SCAN_FLIP);
    assign bit_cnt_inc = bit_cnt_q + NBITS_W'(1);
    assign cmd_done    = (bit_cnt_q == nbits_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        nbits_d   = nbits_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        word_d    = word_q;
        rd_d      = rd_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        err_d     = 1'b0;
        load_bit  = 1'b0;
        bit_val   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    nbits_d   = cmd_nbits_i;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    rd_d      = '0;
                    if (!op_is_legal(cmd_op_i)) begin
                        err_d = 1'b1;
                    end else begin
                        op_d = op_e'(cmd_op_i);
                        if (op_e'(cmd_op_i) == OP_RESET) begin
                            state_d  = ST_LOW;
                            load_bit = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
            end

            ST_FETCH: begin
                // Only reachable with nothing left to shift for nbits=0;
                // that command then takes exactly this one busy cycle.
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end else if (wr_valid_i) begin
                    word_d   = wr_data_i;
                    rd_d     = '0;
                    state_d  = ST_LOW;
                    load_bit = 1'b1;
                    bit_val  = wr_data_i[0];
                end
            end

            ST_LOW: begin
                if (rise_stb) begin
                    state_d = ST_HIGH;
                    if (scan_op) begin
                        rd_d[idx_q] = tdo_i;
                    end
                end
            end

            ST_HIGH: begin
                if (bit_done_stb) begin
                    bit_cnt_d = bit_cnt_inc;
                    idx_d     = idx_q + 5'd1;
                    if (op_q == OP_RESET) begin
                        if (bit_cnt_inc == NBITS_W'(RESET_BITS)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_LOW;
                            load_bit = 1'b1;
                        end
                    end else if (bit_cnt_inc == nbits_q) begin
                        state_d = scan_op ? ST_STORE : ST_IDLE;
                    end else if (idx_q == 5'd31) begin
                        // Word exhausted: hand the capture out before asking
                        // for the next word.
                        state_d = scan_op ? ST_STORE : ST_FETCH;
                    end else begin
                        state_d  = ST_LOW;
                        load_bit = 1'b1;
                        bit_val  = word_q[idx_d];
                    end
                end
            end

            ST_STORE: begin
                if (rd_ready_i) begin
                    state_d = cmd_done ? ST_IDLE : ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // TMS/TDI are registered alongside the move into LOW, so they are
        // valid from the first LOW cycle and stable across the TCK rise.
        if (load_bit) begin
            case (op_d)
                OP_TMS_SEQ: begin
                    tms_d = bit_val;
                    tdi_d = 1'b0;
                end
                OP_SCAN: begin
                    tms_d = 1'b0;
                    tdi_d = bit_val;
                end
                OP_SCAN_FLIP: begin
                    tms_d = ((bit_cnt_d + NBITS_W'(1)) == nbits_d);
                    tdi_d = bit_val;
                end
                default: begin
                    tms_d = (bit_cnt_d < NBITS_W'(RESET_TMS_ONES));
                    tdi_d = 1'b0;
                end
            endcase
        end

        if (state_d == ST_IDLE) begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RESET;
            nbits_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            rd_q      <= '0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            nbits_q   <= nbits_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            rd_q      <= rd_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            err_q     <= err_d;
        end
    end

`ifdef JTAG_SEQ_TRST_EN
    logic trst_n_q, trst_n_d;

    // Low for exactly the TMS=1 bits of a TAP reset command; comes out of
    // reset low and is released on the first clock afterwards.
    assign trst_n_d = !(((state_d == ST_LOW) || (state_d == ST_HIGH)) &&
                        (op_d == OP_RESET) &&
                        (bit_cnt_d < NBITS_W'(RESET_TMS_ONES)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trst_n_q <= 1'b0;
        end else begin
            trst_n_q <= trst_n_d;
        end
    end

    assign trst_n_o = trst_n_q;
`endif

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign wr_ready_o  = (state_q == ST_FETCH) && !cmd_done;
    assign rd_valid_o  = (state_q == ST_STORE);
    assign rd_data_o   = rd_q;
    assign err_o       = err_q;
    assign tck_o       = tck;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule : jtag_seq_ctrl

// File: doc/jtag_seq_ctrl.md
Name: jtag_seq_ctrl

Overview:
- Synthesizable JTAG master sequencer that replaces the simulation-only TCP/VPI JTAG driver on FPGA targets.
- Accepts host commands (TAP reset, TMS sequence, scan, scan with final-bit TMS flip) over a valid/ready interface and streams 32-bit TDI words in.
- Generates divided TCK/TMS/TDI and returns captured TDO words.
- Sits between the debug host bridge and the debug TAP (adv_debug_sys).

Parameters:
- TCK_DIV, 4, TCK half period in clk_i cycles; legal range 1..255.
- NBITS_W, 16, width of the bit-count field; maximum scan length is 2^NBITS_W-1 bits.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_op_i  in  3  0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP_TMS, others illegal.
- cmd_nbits_i  in  NBITS_W  bit count; ignored for RESET.
- wr_valid_i / wr_ready_o  in/out  1  outbound data word handshake.
- wr_data_i  in  32  TMS or TDI bits, LSB shifted first.
- rd_valid_o / rd_ready_i  out/in  1  captured TDO word handshake.
- rd_data_o  out  32  captured TDO bits, first bit at LSB.
- busy_o  out  1  high whenever the block is not in IDLE.
- err_o  out  1  one-cycle pulse when an illegal op is accepted.
- tck_o, tms_o, tdi_o  out  1  JTAG outputs, all registered.
- tdo_i  in  1  JTAG TDO.

Behaviour:
- Reset values while rst_n_i is low: tck_o=0, tms_o=0, tdi_o=0, rd_valid_o=0, wr_ready_o=0, busy_o=0, err_o=0, cmd_ready_o=1, rd_data_o=0.
- Reset asserted mid-operation aborts the operation immediately; partial words are discarded.
- State machine: IDLE, FETCH, LOW, HIGH, STORE.
- cmd_ready_o = (state==IDLE). The handshake latches op and nbits, and clears the bit counter.
- Bit timing, per bit:
  - LOW: tms_o and tdi_o update on the first cycle, tck_o=0 for TCK_DIV cycles.
  - HIGH: tck_o=1 for TCK_DIV cycles; tdo_i is sampled on the clk_i edge where tck_o goes 0→1.
  - One bit takes 2*TCK_DIV cycles.
- RESET: 5 bits with TMS=1, then 1 bit with TMS=0. Consumes and produces no words. Returns to IDLE.
- TMS_SEQ:
  - FETCH raises wr_ready_o until a wr handshake, then shifts min(32, remaining) bits with tms_o=word bit and tdi_o=0.
  - Produces no rd words.
- SCAN / SCAN_FLIP_TMS:
  - Same word fetch as TMS_SEQ; tdi_o=word bit.
  - tms_o=0, except tms_o=1 on the final bit of the whole command when the op is SCAN_FLIP_TMS.
  - After each 32 bits, or after the final bit, go to STORE: rd_valid_o=1 until rd_ready_i.
  - A partial final word is zero-filled above bit (n-1).
  - Words produced per command = ceil(nbits/32).
- End of command: tms_o=0 and tdi_o=0 on the cycle of return to IDLE; tck_o remains 0.
- Stalls: while waiting in FETCH or STORE, tck_o is held 0 (TCK stretching is legal). No TCK edges occur without data available.
- wr_ready_o and rd_valid_o are never high simultaneously. STORE completes before the next FETCH.
- nbits=0 for TMS_SEQ/SCAN: the command completes in one cycle with no TCK, no wr or rd words, and busy_o high for 1 cycle.
- Illegal op: accepted, err_o pulses 1 cycle, no JTAG activity.
- Counters: the bit counter is NBITS_W wide; the word bit index is 5 bits and wraps 31→0, triggering FETCH/STORE.

Optional Feature:
- Macro JTAG_SEQ_TRST_EN.
- When defined: adds output port trst_n_o (reset value 0, released to 1 on the first cycle after reset deassertion). During RESET, trst_n_o=0 for the 5 TMS=1 bits and 1 otherwise.
- When undefined: port absent; RESET uses the TMS sequence only.

Decomposition:
- Package jtag_seq_pkg holds:
  - op encodings OP_RESET=0, OP_TMS_SEQ=1, OP_SCAN=2, OP_SCAN_FLIP=3;
  - state encodings;
  - RESET_TMS_ONES=5.
- Sub-module jtag_tck_gen: TCK_DIV phase counter with inputs run and clk_i/rst_n_i, and outputs tck, rise_stb and bit_done_stb. The FSM gates run low during FETCH/STORE.

Test Plan:
- TCK_DIV=2, RESET → exactly 6 tck_o rising edges, TMS pattern 1,1,1,1,1,0; 24 clk cycles; busy_o then low.
- TMS_SEQ nbits=5, word 0x0000_0016 → TMS on rising edges 0,1,1,0,1; no rd_valid_o; tdi_o=0 throughout.
- SCAN nbits=40, words 0xA5A5_A5A5, 0x0000_00FF, tdo_i looped from tdi_o → rd words 0xA5A5_A5A5 then 0x0000_00FF; tms_o=0 on all 40 edges.
- SCAN_FLIP_TMS nbits=8, word 0x3C, tdo_i=1 → tms_o=1 only on the 8th rising edge; rd word 0x0000_00FF; tms_o=0 afterwards.
- Backpressure: SCAN nbits=64 with wr_valid_i delayed 10 cycles and rd_ready_i held low 7 cycles → tck_o stays 0 during both stalls; data is bit-exact.
- rst_n_i pulsed low mid-SCAN (bit 17 of 40) → all outputs at reset values within the same cycle; a following RESET command runs normally; nbits=0 SCAN and op=6 → no TCK edges; err_o pulses once, for op=6 only.
